booth_accumulator: RTL and testbench
====================================

Name: booth_accumulator

Overview:
- Downstream stage of the 8x8 signed Booth multiplier top: consumes 16-bit signed products and accumulates a fixed-length vector of them into a wider signed sum (dot-product / MAC back end).
- Accepts one product per cycle on a valid/ready handshake.
- Presents the finished sum on a registered valid/ready output with a sticky saturation flag.
- The product valid strobe comes from a valid pipeline matched to the multiplier latency; that pipeline is outside this block.

Parameters:
- PROD_W, 16, product width (signed, two's complement).
- ACC_W, 24, accumulator/result width; must be >= PROD_W.
- VEC_LEN, 8, products per accumulated vector; must be >= 1.

Ports:
- CLK  input  1  clock, all state on rising edge.
- RST  input  1  reset; synchronous and active-high.
- clear  input  1  synchronous abort of the current vector.
- prod_valid  input  1  prod_data is valid.
- prod_data  input  PROD_W  signed product from the multiplier stage.
- prod_ready  output  1  block can accept a product this cycle.
- acc_valid  output  1  acc_data/acc_ovf hold a completed vector sum.
- acc_ready  input  1  consumer accepts the sum.
- acc_data  output  ACC_W  signed accumulated sum.
- acc_ovf  output  1  saturation occurred at least once in this vector.

Behaviour:
- Reset values: acc_valid=0, acc_data=0, acc_ovf=0. Internal sum=0, count=0, state=ACCUM. prod_ready=1 from the first cycle after reset.
- Event priority: RST > clear > handshakes.
- States:
  - ACCUM: prod_ready=1, acc_valid=0.
  - HOLD: prod_ready=0, acc_valid=1.
- prod_ready and acc_valid are pure functions of the registered state.
- Accept in ACCUM: prod_valid&&prod_ready at an edge updates the sum:
  - Sign-extend prod_data to ACC_W and add to the sum.
  - Saturating: positive overflow clamps to 2^(ACC_W-1)-1; negative overflow clamps to -2^(ACC_W-1).
  - Any clamp sets the sticky overflow bit.
  - count increments.
- Last product: the accept with count==VEC_LEN-1 does all of the following at that edge:
  - Loads the final saturated sum into acc_data and the sticky bit into acc_ovf.
  - Enters HOLD and resets count to 0.
  - acc_valid is high in the next cycle, i.e. 1-cycle latency from last accept to valid.
- HOLD:
  - acc_data and acc_ovf are stable while acc_valid && !acc_ready.
  - prod_valid is ignored and no product is consumed.
  - acc_valid&&acc_ready at an edge returns to ACCUM with internal sum and sticky bit cleared. prod_ready=1 the next cycle; there is no same-cycle product accept.
  - acc_data/acc_ovf keep their last values after the handshake (don't-care while acc_valid=0).
- VEC_LEN=1: every accepted product goes straight to HOLD; a full cycle alternates ACCUM/HOLD.
- clear, any state:
  - Next cycle state=ACCUM, sum=0, count=0, sticky=0, acc_valid=0.
  - A product or result handshake coincident with clear is discarded.
- RST mid-operation (including HOLD with a pending result): the result is dropped and all reset values are restored.
- prod_valid with X/idle data is never sampled unless prod_ready=1.

Decomposition:
- Package booth_pkg holds:
  - Localparams PROD_W_DEF=16, ACC_W_DEF=24, VEC_LEN_DEF=8.
  - State enum {ACCUM, HOLD}.
  - Count width = $clog2(VEC_LEN+1).
- One combinational sub-module, booth_sat_add. It sign-extends the PROD_W input, adds it to the ACC_W operand, and outputs the clamped sum plus an ovf bit. Overflow detection uses the sign of both operands vs. the raw result.
- The FSM, counter and output registers stay in booth_accumulator.

Test Plan:
- Basic: 8 accepts of prod_data=100, acc_ready=1 -> acc_valid high exactly 1 cycle after 8th accept, acc_data=800, acc_ovf=0, prod_ready back to 1 the following cycle.
- Signed mix: products +300,-500,+7,-128,+16384,-16384,0,1 -> acc_data=-320 (0xFFFEC0), acc_ovf=0.
- Saturation with ACC_W=18: 8 x 16384 (-128*-128) -> acc_data=131071, acc_ovf=1. With default ACC_W=24 the same stimulus gives 131072, acc_ovf=0.
- Backpressure: complete a vector of 8 x 5, hold acc_ready=0 for 5 cycles while driving prod_valid=1 with 99 -> acc_data stays 40, prod_ready=0 throughout, no 99 accumulated. Next vector of 8 x 1 -> 8.
- Clear mid-vector: 3 accepts of 10, then clear=1 with prod_valid=1, data=50 -> acc_valid stays 0. Subsequent 8 x 1 -> acc_data=8.
- Reset in HOLD: RST=1 for one cycle while acc_valid=1 -> next cycle acc_valid=0, acc_data=0, acc_ovf=0, prod_ready=1. Next vector 8 x 2 -> 16.

Source files
------------

// File: rtl/booth_pkg.sv
// Shared definitions for the Booth multiplier accumulator back end.
// Holds the default widths, the accumulator state encoding and a helper
// that sizes the product counter from the vector length.
package booth_pkg;

    localparam int unsigned PROD_W_DEF  = 16;
    localparam int unsigned ACC_W_DEF   = 24;
    localparam int unsigned VEC_LEN_DEF = 8;

    typedef enum logic {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } state_t;

    // Counter width able to hold 0..vec_len
    function automatic int unsigned cnt_w(input int unsigned vec_len);
        return $clog2(vec_len + 1);
    endfunction

endpackage

// File: rtl/booth_sat_add.sv
// Saturating signed adder: sign-extends a product and adds it to the
// running sum, clamping to the ACC_W two's-complement range.
// Ports:
//   acc    - current ACC_W signed sum
//   prod   - PROD_W signed product
//   sum_c  - clamped ACC_W result (combinational)
//   ovf_c  - high when the result was clamped (combinational)
module booth_sat_add #(
    parameter int unsigned PROD_W = 16,
    parameter int unsigned ACC_W  = 24
) (
    input  logic [ACC_W-1:0]  acc,
    input  logic [PROD_W-1:0] prod,
    output logic [ACC_W-1:0]  sum_c,
    output logic              ovf_c
);

    localparam logic [ACC_W-1:0] SAT_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic [ACC_W-1:0] SAT_MIN = {1'b1, {(ACC_W-1){1'b0}}};

    logic [ACC_W-1:0] prod_ext;
    logic [ACC_W-1:0] raw;
    logic             pos_ovf;
    logic             neg_ovf;

    // Overflow only when both operands share a sign the raw result lacks
    always_comb begin
        prod_ext = ACC_W'($signed(prod));
        raw      = acc + prod_ext;
        pos_ovf  = !acc[ACC_W-1] && !prod_ext[ACC_W-1] &&  raw[ACC_W-1];
        neg_ovf  =  acc[ACC_W-1] &&  prod_ext[ACC_W-1] && !raw[ACC_W-1];
        ovf_c    = pos_ovf || neg_ovf;
        if (pos_ovf) begin
            sum_c = SAT_MAX;
        end else if (neg_ovf) begin
            sum_c = SAT_MIN;
        end else begin
            sum_c = raw;
        end
    end

endmodule

// File: rtl/booth_accumulator.sv
// Accumulates VEC_LEN signed products into a saturating ACC_W sum and
// presents the completed sum on a valid/ready output with a sticky
// overflow flag.
// Ports:
//   CLK, RST    - clock, synchronous active-high reset
//   clear       - synchronous abort of the current vector
//   prod_valid  - product input valid
//   prod_data   - PROD_W signed product
//   prod_ready  - block accepts a product this cycle (ACCUM state)
//   acc_valid   - acc_data/acc_ovf hold a completed sum (HOLD state)
//   acc_ready   - consumer accepts the sum
//   acc_data    - ACC_W signed vector sum
//   acc_ovf     - saturation occurred somewhere in the vector
module booth_accumulator
    import booth_pkg::*;
#(
    parameter int unsigned PROD_W  = PROD_W_DEF,
    parameter int unsigned ACC_W   = ACC_W_DEF,
    parameter int unsigned VEC_LEN = VEC_LEN_DEF
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              clear,
    input  logic              prod_valid,
    input  logic [PROD_W-1:0] prod_data,
    output logic              prod_ready,
    output logic              acc_valid,
    input  logic              acc_ready,
    output logic [ACC_W-1:0]  acc_data,
    output logic              acc_ovf
);

    localparam int unsigned     CNT_W = cnt_w(VEC_LEN);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(VEC_LEN - 1);

    state_t           state, state_n;
    logic [ACC_W-1:0] sum, sum_n;
    logic             sticky, sticky_n;
    logic [CNT_W-1:0] count, count_n;
    logic [ACC_W-1:0] acc_data_n;
    logic             acc_ovf_n;

    logic [ACC_W-1:0] add_sum;
    logic             add_ovf;
    logic             accept;
    logic             deliver;

    booth_sat_add #(
        .PROD_W (PROD_W),
        .ACC_W  (ACC_W)
    ) u_sat_add (
        .acc   (sum),
        .prod  (prod_data),
        .sum_c (add_sum),
        .ovf_c (add_ovf)
    );

    // Handshake qualifiers are decoded from the registered state only
    assign prod_ready = (state == ACCUM);
    assign acc_valid  = (state == HOLD);
    assign accept     = prod_valid && prod_ready;
    assign deliver    = acc_valid && acc_ready;

    // Next-state and datapath update; clear overrides any handshake
    always_comb begin
        state_n    = state;
        sum_n      = sum;
        sticky_n   = sticky;
        count_n    = count;
        acc_data_n = acc_data;
        acc_ovf_n  = acc_ovf;

        if (clear) begin
            state_n  = ACCUM;
            sum_n    = '0;
            sticky_n = 1'b0;
            count_n  = '0;
        end else begin
            case (state)
                ACCUM: begin
                    if (accept) begin
                        sum_n    = add_sum;
                        sticky_n = sticky || add_ovf;
                        if (count == LAST) begin
                            acc_data_n = add_sum;
                            acc_ovf_n  = sticky || add_ovf;
                            state_n    = HOLD;
                            count_n    = '0;
                        end else begin
                            count_n = count + 1'b1;
                        end
                    end
                end
                HOLD: begin
                    // Result consumed: start a fresh vector next cycle
                    if (deliver) begin
                        state_n  = ACCUM;
                        sum_n    = '0;
                        sticky_n = 1'b0;
                    end
                end
                default: begin
                    state_n = ACCUM;
                end
            endcase
        end
    end

    // State and output registers
    always_ff @(posedge CLK) begin
        if (RST) begin
            state    <= ACCUM;
            sum      <= '0;
            sticky   <= 1'b0;
            count    <= '0;
            acc_data <= '0;
            acc_ovf  <= 1'b0;
        end else begin
            state    <= state_n;
            sum      <= sum_n;
            sticky   <= sticky_n;
            count    <= count_n;
            acc_data <= acc_data_n;
            acc_ovf  <= acc_ovf_n;
        end
    end

endmodule

// File: tb/tb_booth_accumulator.sv
// Bench for booth_accumulator: directed scenarios plus random vectors,
// checked against an arithmetic saturating-sum model. A second instance
// with ACC_W=18 shares all inputs to exercise saturation.
module tb_booth_accumulator;

    logic        CLK;
    logic        RST;
    logic        clear;
    logic        prod_valid;
    logic [15:0] prod_data;
    logic        acc_ready;

    logic        prod_ready, acc_valid, acc_ovf;
    logic [23:0] acc_data;
    logic        prod_ready_n, acc_valid_n, acc_ovf_n;
    logic [17:0] acc_data_n;

    int total = 0;
    int bad   = 0;
    int vec[$];

    booth_accumulator dut (
        .CLK        (CLK),
        .RST        (RST),
        .clear      (clear),
        .prod_valid (prod_valid),
        .prod_data  (prod_data),
        .prod_ready (prod_ready),
        .acc_valid  (acc_valid),
        .acc_ready  (acc_ready),
        .acc_data   (acc_data),
        .acc_ovf    (acc_ovf)
    );

    booth_accumulator #(.ACC_W(18)) dut_n (
        .CLK        (CLK),
        .RST        (RST),
        .clear      (clear),
        .prod_valid (prod_valid),
        .prod_data  (prod_data),
        .prod_ready (prod_ready_n),
        .acc_valid  (acc_valid_n),
        .acc_ready  (acc_ready),
        .acc_data   (acc_data_n),
        .acc_ovf    (acc_ovf_n)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Saturating sum of the current vector in a w-bit signed accumulator
    function automatic void model(input int w, output longint s, output bit o);
        longint mx = (longint'(1) <<< (w - 1)) - 1;
        longint mn = -(longint'(1) <<< (w - 1));
        s = 0;
        o = 1'b0;
        foreach (vec[i]) begin
            s = s + vec[i];
            if (s > mx) begin s = mx; o = 1'b1; end
            if (s < mn) begin s = mn; o = 1'b1; end
        end
    endfunction

    function automatic logic [63:0] wrap(input longint s, input int w);
        return 64'(s & ((longint'(1) <<< w) - 1));
    endfunction

    // Offer one product and wait (bounded) until it is taken
    task automatic push(input int p);
        int n = 0;
        vec.push_back(p);
        prod_data  = 16'(p);
        prod_valid = 1'b1;
        while (!prod_ready && n < 20) begin
            @(posedge CLK); #1;
            n++;
        end
        if (!prod_ready) begin
            total++;
            bad++;
            $error("FAIL push_timeout observed=prod_ready_low expected=prod_ready_high");
        end else begin
            chk("valid_before_accept", 64'(acc_valid), 64'd0);
            @(posedge CLK); #1;
        end
    endtask

    // Check the completed vector, optionally stall, then consume it
    task automatic fin(input int hold);
        longint s24, s18;
        bit     o24, o18;
        logic [23:0] held;
        model(24, s24, o24);
        model(18, s18, o18);
        acc_ready  = 1'b0;
        prod_valid = (hold > 0);
        prod_data  = 16'd99;
        chk("valid_latency", 64'(acc_valid), 64'd1);
        chk("ready_in_hold", 64'(prod_ready), 64'd0);
        chk("data24", 64'(acc_data), wrap(s24, 24));
        chk("ovf24", 64'(acc_ovf), 64'(o24));
        chk("data18", 64'(acc_data_n), wrap(s18, 18));
        chk("ovf18", 64'(acc_ovf_n), 64'(o18));
        held = acc_data;
        for (int i = 0; i < hold; i++) begin
            @(posedge CLK); #1;
            chk("hold_stable", 64'(acc_data), 64'(held));
            chk("hold_ready", 64'(prod_ready), 64'd0);
            chk("hold_valid", 64'(acc_valid), 64'd1);
        end
        acc_ready = 1'b1;
        @(posedge CLK); #1;
        acc_ready  = 1'b0;
        prod_valid = 1'b0;
        chk("after_deliver_valid", 64'(acc_valid), 64'd0);
        chk("after_deliver_ready", 64'(prod_ready), 64'd1);
        vec.delete();
    endtask

    initial begin
        int mix[8] = '{300, -500, 7, -128, 16384, -16384, 0, 1};
        RST        = 1'b1;
        clear      = 1'b0;
        prod_valid = 1'b0;
        prod_data  = 16'd0;
        acc_ready  = 1'b0;
        repeat (2) @(posedge CLK);
        #1 RST = 1'b0;

        // Reset state
        chk("rst_valid", 64'(acc_valid), 64'd0);
        chk("rst_data", 64'(acc_data), 64'd0);
        chk("rst_ovf", 64'(acc_ovf), 64'd0);
        chk("rst_ready", 64'(prod_ready), 64'd1);

        // Basic
        for (int i = 0; i < 8; i++) push(100);
        fin(0);
        chk("basic_const", 64'(acc_data), 64'd800);

        // Signed mix
        foreach (mix[i]) push(mix[i]);
        fin(0);
        chk("mix_const", 64'(acc_data), 64'hFFFEC0);

        // Saturation only in the 18-bit instance
        for (int i = 0; i < 8; i++) push(16384);
        fin(0);
        chk("sat18_const", 64'(acc_data_n), 64'd131071);
        chk("sat18_ovf", 64'(acc_ovf_n), 64'd1);
        chk("sat24_const", 64'(acc_data), 64'd131072);

        // Backpressure with products offered during HOLD
        for (int i = 0; i < 8; i++) push(5);
        fin(5);
        chk("bp_const", 64'(acc_data), 64'd40);
        for (int i = 0; i < 8; i++) push(1);
        fin(0);
        chk("bp_next_const", 64'(acc_data), 64'd8);

        // Clear mid-vector with a coincident product
        for (int i = 0; i < 3; i++) push(10);
        clear      = 1'b1;
        prod_valid = 1'b1;
        prod_data  = 16'd50;
        @(posedge CLK); #1;
        clear      = 1'b0;
        prod_valid = 1'b0;
        vec.delete();
        chk("clear_valid", 64'(acc_valid), 64'd0);
        chk("clear_ready", 64'(prod_ready), 64'd1);
        for (int i = 0; i < 8; i++) push(1);
        fin(0);
        chk("clear_next_const", 64'(acc_data), 64'd8);

        // Reset while a result is pending
        for (int i = 0; i < 8; i++) push(3);
        prod_valid = 1'b0;
        chk("pre_rst_valid", 64'(acc_valid), 64'd1);
        RST = 1'b1;
        @(posedge CLK); #1;
        RST = 1'b0;
        vec.delete();
        chk("rsthold_valid", 64'(acc_valid), 64'd0);
        chk("rsthold_data", 64'(acc_data), 64'd0);
        chk("rsthold_ovf", 64'(acc_ovf), 64'd0);
        chk("rsthold_ready", 64'(prod_ready), 64'd1);
        for (int i = 0; i < 8; i++) push(2);
        fin(0);
        chk("rst_next_const", 64'(acc_data), 64'd16);

        // Random vectors with idle gaps and random result stalls
        for (int v = 0; v < 30; v++) begin
            for (int i = 0; i < 8; i++) begin
                logic signed [15:0] r;
                r = 16'($urandom);
                if (v % 3 == 0) r = 16'(r >>> 6);
                push(int'(r));
                if ($urandom_range(0, 3) == 0) begin
                    prod_valid = 1'b0;
                    prod_data  = 16'($urandom);
                    repeat ($urandom_range(1, 2)) begin
                        @(posedge CLK); #1;
                    end
                end
            end
            fin(int'($urandom_range(0, 3)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
